rsa_operand_sequencer: RTL
==========================

// Module: rsa_operand_sequencer
// PURPOSE
//   Sits directly downstream of the AHB register slave in the PicoRV32 RSA SoC and feeds the
//   RSA modexp core. CPU word writes become wide BASE/EXP/MOD operands. The block issues
//   core_start, waits for core_done, then exposes the wide result as readable 32-bit words.
// PARAMETERS
//   KEY_W       128    operand/result width in bits; must be a multiple of 32
//   NWORDS      KEY_W/32  words per operand (derived, localparam)
//   TIMEOUT_CYC 65535  watchdog limit in cycles; used only with RSA_SEQ_TIMEOUT_EN
// PORTS
//   hclk         in   1      single clock shared with the AHB register slave
//   hresetn      in   1      asynchronous, active-low reset
//   wr_en        in   1      one-cycle register write strobe from the register slave
//   wr_addr      in   4      register offset for the write
//   wr_data      in   32     write data
//   rd_en        in   1      one-cycle register read strobe
//   rd_addr      in   4      register offset for the read
//   rd_data      out  32     read data, registered
//   core_start   out  1      one-cycle start pulse to the RSA core
//   core_base    out  KEY_W  base operand
//   core_exp     out  KEY_W  exponent operand
//   core_mod     out  KEY_W  modulus operand
//   core_done    in   1      one-cycle completion pulse from the RSA core
//   core_result  in   KEY_W  result; valid in the core_done cycle
//   irq          out  1      level interrupt: high while DONE is set or ERR is set
// BEHAVIOUR
//   Register map:
//     0x0 CTRL    write-only: bit0=START, bit1=CLEAR
//     0x1 STATUS  read-only: bit0=BUSY, bit1=DONE, bit2=ERR, bits[7:4]=state
//     0x2 BASE    write window
//     0x3 EXP     write window
//     0x4 MOD     write window
//     0x5 RESULT  read window
//     other       reads return 0; writes ignored
//   Windows: each window has its own word pointer, LS word first.
//     - A write stores wr_data into word[ptr]; ptr then advances modulo NWORDS
//       (word NWORDS wraps to word 0).
//     - A RESULT read returns result word[rptr]; rptr then advances modulo NWORDS.
//   Read latency: rd_data is valid 1 cycle after rd_en. rd_data holds its value otherwise.
//   FSM states: IDLE(0), START(1), WAIT(2), DONE(3).
//     IDLE  --START--------> START
//     START --1 cycle------> WAIT   (core_start=1 only during START)
//     WAIT  --core_done----> DONE   (capture core_result, rptr=0, DONE=1)
//     DONE  --START--------> START  (DONE cleared)
//     DONE  --CLEAR--------> IDLE
//   While BUSY (START or WAIT):
//     - operand writes are ignored and set sticky ERR; operands stay stable
//     - START is ignored and sets ERR
//     - CLEAR aborts to IDLE; a core_done in the same cycle is discarded
//   CLEAR in any state: all pointers=0, DONE=0, ERR=0; operand contents are kept.
//   START and CLEAR written together: CLEAR wins; no start is issued.
//   Reset values: state=IDLE, all pointers=0, operands=0, result=0, rd_data=0,
//     core_start=0, irq=0, DONE=0, ERR=0.
//   A core_done outside WAIT is ignored.
// CONFIGURATION
//   RSA_SEQ_TIMEOUT_EN defined:
//     - a counter clears on entry to WAIT and increments each WAIT cycle
//     - reaching TIMEOUT_CYC sets ERR and forces IDLE; DONE stays 0
//     - STATUS bit3 = TIMEOUT (sticky; cleared by CLEAR)
//   RSA_SEQ_TIMEOUT_EN undefined: WAIT holds until core_done or CLEAR; STATUS bit3 reads 0.
// STRUCTURE
//   Package rsa_seq_pkg: register offset constants, CTRL/STATUS bit positions,
//     FSM state encoding.
//   Sub-module rsa_word_packer:
//     - NWORDS x 32 word store with a wrapping pointer and write enable
//     - clear input that zeroes the pointer
//     - flat KEY_W output
//     - instantiated three times (BASE, EXP, MOD)
// TESTING
//   1. Reset, then load operands (KEY_W=128):
//      - write BASE 0x4,0x3,0x2,0x1 -> core_base=0x00000001_00000002_00000003_00000004
//      - likewise EXP and MOD
//      - a 5th BASE write of 0xA -> overwrites word0 only
//   2. Run: CTRL=0x1 -> core_start high for exactly 1 cycle; STATUS=0x21 (BUSY, state 2).
//      - core_done with result 0xDEADBEEF_..._CAFEF00D -> STATUS=0x32, irq=1
//      - 4 RESULT reads return LS word first
//   3. While in WAIT:
//      - write BASE 0x55 -> core_base unchanged, ERR=1
//      - CTRL=0x1 -> no second core_start
//   4. Abort: CTRL=0x2 in WAIT with core_done in the same cycle -> state IDLE, DONE=0,
//      rd_data(STATUS)=0x00.
//   5. Reset mid-run: drop hresetn in WAIT -> all outputs 0 at once (async); state IDLE.
//   6. With RSA_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: never assert core_done ->
//      at cycle 16 in WAIT, ERR=1, TIMEOUT=1, state IDLE, irq=1.

Source files
------------

// File: rtl/rsa_operand_sequencer_pkg.sv
// Shared constants for the RSA operand sequencer: register offsets, CTRL/STATUS bit
// positions and the sequencer FSM encoding.
package rsa_seq_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_BASE   = 4'h2;
  localparam logic [3:0] REG_EXP    = 4'h3;
  localparam logic [3:0] REG_MOD    = 4'h4;
  localparam logic [3:0] REG_RESULT = 4'h5;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ERR_BIT     = 2;
  localparam int STAT_TIMEOUT_BIT = 3;
  localparam int STAT_STATE_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rsa_operand_sequencer_if.sv
// Register-slave side bus of the RSA operand sequencer: one-cycle write and read strobes
// with a registered read-data return.
interface rsa_operand_sequencer_if;

  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);

endinterface

// File: rtl/rsa_word_packer.sv
// Assembles 32-bit CPU writes into one KEY_W-bit operand, LS word first, with a pointer
// that wraps after the last word and can be cleared back to word 0.
module rsa_word_packer #(
  parameter int KEY_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic [KEY_W-1:0]  word
);

  localparam int NWORDS = KEY_W / 32;
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [PTR_W-1:0] ptr_r;

  // Word pointer: clear has priority over a write advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (clear) begin
      ptr_r <= '0;
    end else if (wr_en) begin
      if (ptr_r == PTR_W'(NWORDS - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + PTR_W'(1);
      end
    end
  end

  // Word store; contents survive clear and only change on an enabled write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (ptr_r == PTR_W'(i)) begin
          word[i*32 +: 32] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_operand_sequencer.sv
// Collects BASE/EXP/MOD operands from register writes, runs the RSA core and exposes its
// result as 32-bit read words. Optional watchdog: define RSA_SEQ_TIMEOUT_EN.
module rsa_operand_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int KEY_W       = 128,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  rsa_operand_sequencer_if.slave bus,
  output logic                  core_start,
  output logic [KEY_W-1:0]      core_base,
  output logic [KEY_W-1:0]      core_exp,
  output logic [KEY_W-1:0]      core_mod,
  input  logic                  core_done,
  input  logic [KEY_W-1:0]      core_result,
  output logic                  irq
);

  localparam int NWORDS = KEY_W / 32;
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  if (((KEY_W % 32) != 0) || (KEY_W < 32) || (TIMEOUT_CYC < 1)) begin : g_bad_params
    $error("rsa_operand_sequencer: KEY_W must be a positive multiple of 32 and TIMEOUT_CYC >= 1");
  end

  seq_state_e       state_r, state_n;
  logic             done_r, done_n;
  logic             err_r, err_n;
  logic             timeout_r, timeout_n;
  logic             capture_s;
  logic             timeout_hit_s;
  logic [KEY_W-1:0] result_r;
  logic [PTR_W-1:0] rptr_r;
  logic [31:0]      result_words_s [NWORDS];
  logic [31:0]      status_s;
  logic [31:0]      rd_word_s;

  logic ctrl_wr_s, start_req_s, clear_req_s, busy_s, op_wr_s;
  logic base_we_s, exp_we_s, mod_we_s, result_rd_s;

  assign ctrl_wr_s   = bus.wr_en && (bus.wr_addr == REG_CTRL);
  assign start_req_s = ctrl_wr_s && bus.wr_data[CTRL_START_BIT];
  assign clear_req_s = ctrl_wr_s && bus.wr_data[CTRL_CLEAR_BIT];
  assign busy_s      = (state_r == ST_START) || (state_r == ST_WAIT);
  assign op_wr_s     = bus.wr_en && ((bus.wr_addr == REG_BASE) || (bus.wr_addr == REG_EXP) ||
                                     (bus.wr_addr == REG_MOD));
  assign base_we_s   = bus.wr_en && (bus.wr_addr == REG_BASE) && !busy_s;
  assign exp_we_s    = bus.wr_en && (bus.wr_addr == REG_EXP)  && !busy_s;
  assign mod_we_s    = bus.wr_en && (bus.wr_addr == REG_MOD)  && !busy_s;
  assign result_rd_s = bus.rd_en && (bus.rd_addr == REG_RESULT);

  rsa_word_packer #(.KEY_W(KEY_W)) u_base (
    .clk(hclk), .rst_n(hresetn), .clear(clear_req_s), .wr_en(base_we_s),
    .wr_data(bus.wr_data), .word(core_base)
  );
  rsa_word_packer #(.KEY_W(KEY_W)) u_exp (
    .clk(hclk), .rst_n(hresetn), .clear(clear_req_s), .wr_en(exp_we_s),
    .wr_data(bus.wr_data), .word(core_exp)
  );
  rsa_word_packer #(.KEY_W(KEY_W)) u_mod (
    .clk(hclk), .rst_n(hresetn), .clear(clear_req_s), .wr_en(mod_we_s),
    .wr_data(bus.wr_data), .word(core_mod)
  );

`ifdef RSA_SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt_r;

  // Watchdog: counts cycles spent in WAIT, restarting from zero on every entry.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt_r <= 32'd0;
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= 32'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end
  end

  assign timeout_hit_s = (state_r == ST_WAIT) && (wait_cnt_r == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and sticky flag logic; CLEAR overrides everything, including a core_done.
  always_comb begin
    state_n   = state_r;
    done_n    = done_r;
    err_n     = err_r;
    timeout_n = timeout_r;
    capture_s = 1'b0;
    if (clear_req_s) begin
      state_n   = ST_IDLE;
      done_n    = 1'b0;
      err_n     = 1'b0;
      timeout_n = 1'b0;
    end else begin
      if ((op_wr_s || start_req_s) && busy_s) begin
        err_n = 1'b1;
      end else begin
        err_n = err_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_req_s) begin
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_START: begin
          state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            state_n   = ST_DONE;
            done_n    = 1'b1;
            capture_s = 1'b1;
          end else if (timeout_hit_s) begin
            state_n   = ST_IDLE;
            err_n     = 1'b1;
            timeout_n = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end
        ST_DONE: begin
          if (start_req_s) begin
            state_n = ST_START;
            done_n  = 1'b0;
          end else begin
            state_n = ST_DONE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, flags and the registered core_start/irq outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      timeout_r  <= 1'b0;
      core_start <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state_r    <= state_n;
      done_r     <= done_n;
      err_r      <= err_n;
      timeout_r  <= timeout_n;
      core_start <= (state_n == ST_START);
      irq        <= done_n | err_n;
    end
  end

  // Result capture and read pointer; a new result or CLEAR restarts reading at word 0.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      result_r <= '0;
      rptr_r   <= '0;
    end else begin
      if (capture_s) begin
        result_r <= core_result;
      end
      if (clear_req_s || capture_s) begin
        rptr_r <= '0;
      end else if (result_rd_s) begin
        if (rptr_r == PTR_W'(NWORDS - 1)) begin
          rptr_r <= '0;
        end else begin
          rptr_r <= rptr_r + PTR_W'(1);
        end
      end
    end
  end

  // Read mux: STATUS fields, RESULT window, zero for everything else.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      result_words_s[i] = result_r[i*32 +: 32];
    end
    status_s = 32'h0;
    status_s[STAT_BUSY_BIT]    = busy_s;
    status_s[STAT_DONE_BIT]    = done_r;
    status_s[STAT_ERR_BIT]     = err_r;
    status_s[STAT_TIMEOUT_BIT] = timeout_r;
    status_s[STAT_STATE_LSB +: 4] = {2'b00, state_r};
    case (bus.rd_addr)
      REG_STATUS: rd_word_s = status_s;
      REG_RESULT: rd_word_s = result_words_s[rptr_r];
      default:    rd_word_s = 32'h0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bus.rd_data <= 32'h0;
    end else if (bus.rd_en) begin
      bus.rd_data <= rd_word_s;
    end
  end

endmodule
